ahb_master_arbiter: RTL and testbench

Round-robin AHB arbiter and address/data multiplexer that lets up to four AHB masters share the single AHB slave port of the AHB-to-APB bridge. It grants one master at a time, tracks address-phase and data-phase ownership across wait states, honours locked transfers and never splits an incrementing burst. It drives the muxed `haddr`/`htrans`/`hwrite`/`hwdata` into the bridge and sits directly upstream of it.

---
 rtl/ahb_master_arbiter.sv | 149 ++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//
// Purpose: round-robin arbiter and address/data multiplexer that lets up to
// four AHB masters share the single AHB slave port of the AHB-to-APB bridge.
// One master is granted at a time. Address-phase ownership (hmaster) and
// data-phase ownership (hmaster_d) are tracked across wait states. Locked
// transfers are honoured, and incrementing bursts are never split.
//
// Ports:
//   hclk, hresetn     clock, asynchronous active-low reset
//   hbusreq, hlock    per-master bus request / locked-transfer request
//   htrans_m          per-master htrans, master i on bits [2i+1:2i]
//   haddr_m           per-master address, master i on bits [32i+31:32i]
//   hwrite_m          per-master write flag
//   hwdata_m          per-master write data, master i on bits [32i+31:32i]
//   hready_in         bus ready from the bridge (hr_readyout)
//   hgrant            one-hot grant
//   hmaster           address-phase owner index
//   hmastlock         current address phase is locked
//   htrans/haddr/hwrite  muxed from the address-phase owner
//   hwdata            muxed from the data-phase owner
module ahb_master_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic [NUM_MASTERS-1:0]      hbusreq,
  input  logic [NUM_MASTERS-1:0]      hlock,
  input  logic [2*NUM_MASTERS-1:0]    htrans_m,
  input  logic [32*NUM_MASTERS-1:0]   haddr_m,
  input  logic [NUM_MASTERS-1:0]      hwrite_m,
  input  logic [32*NUM_MASTERS-1:0]   hwdata_m,
  input  logic                        hready_in,
  output logic [NUM_MASTERS-1:0]      hgrant,
  output logic [1:0]                  hmaster,
  output logic                        hmastlock,
  output logic [1:0]                  htrans,
  output logic [31:0]                 haddr,
  output logic                        hwrite,
  output logic [31:0]                 hwdata
);

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_BUSY = 2'b01;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  // Parking grant: master 0 owns the bus whenever nobody requests it.
  localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1);

  logic [1:0]             hmaster_d;
  logic [1:0]             last;
  logic [1:0]             grant_idx;
  logic                   grant_lock;
  logic                   grant_req;
  logic                   hold_grant;
  logic                   found;
  int                     cand;
  logic [NUM_MASTERS-1:0] next_grant;

  // Encode the one-hot grant into an index. Also pick out the lock and
  // request bits of the granted master, because both are loaded on the next
  // ready edge.
  always_comb begin
    grant_idx  = 2'd0;
    grant_lock = hlock[0];
    grant_req  = hbusreq[0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) begin
        grant_idx  = 2'(i);
        grant_lock = hlock[i];
        grant_req  = hbusreq[i];
      end
    end
  end

  // Address-phase signals follow hmaster. Write data follows hmaster_d,
  // which lags by one ready edge, so hwdata stays with the previous address
  // phase across a handover. Out-of-range indices fall back to master 0.
  always_comb begin
    htrans = htrans_m[1:0];
    haddr  = haddr_m[31:0];
    hwrite = hwrite_m[0];
    hwdata = hwdata_m[31:0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (hmaster == 2'(i)) begin
        htrans = htrans_m[2*i +: 2];
        haddr  = haddr_m[32*i +: 32];
        hwrite = hwrite_m[i];
      end
      if (hmaster_d == 2'(i)) begin
        hwdata = hwdata_m[32*i +: 32];
      end
    end
  end

  // The owner keeps the grant during a locked sequence that is still moving,
  // and in the middle of a burst (SEQ/BUSY). This prevents a burst from
  // being split.
  assign hold_grant = (hmastlock && (htrans != TRANS_IDLE)) ||
                      (htrans == TRANS_SEQ) || (htrans == TRANS_BUSY);

  // Round-robin search that starts just after the most recent owner. The
  // last candidate visited is the most recent owner itself, so it keeps the
  // bus only when nobody else is asking. If there are no requests, the grant
  // parks on master 0.
  always_comb begin
    next_grant = PARK_GRANT;
    found      = 1'b0;
    cand       = 0;
    if (hold_grant) begin
      next_grant = hgrant;
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        cand = int'(last) + k;
        if (cand >= NUM_MASTERS) begin
          cand = cand - NUM_MASTERS;
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
          if (!found && (j == cand) && hbusreq[j]) begin
            next_grant    = '0;
            next_grant[j] = 1'b1;
            found         = 1'b1;
          end
        end
      end
    end
  end

  // All arbitration state advances only on ready edges, so wait states
  // freeze grant, ownership, lock and the round-robin pointer together.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant    <= PARK_GRANT;
      hmaster   <= 2'd0;
      hmaster_d <= 2'd0;
      hmastlock <= 1'b0;
      last      <= 2'd0;
    end else if (hready_in) begin
      hgrant    <= next_grant;
      hmaster   <= grant_idx;
      hmastlock <= grant_lock;
      hmaster_d <= hmaster;
      if (grant_req) begin
        last <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter
//
// Purpose: directed test of ahb_master_arbiter. Each step drives inputs and
// queues the expected arbiter state. After the next clock edge, the queued
// entry is popped and compared with the muxed outputs.
module tb_ahb_master_arbiter;

  localparam int N = 4;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [N-1:0]  hbusreq;
  logic [N-1:0]  hlock;
  logic [2*N-1:0]  htrans_m;
  logic [32*N-1:0] haddr_m;
  logic [N-1:0]  hwrite_m;
  logic [32*N-1:0] hwdata_m;
  logic          hready_in;
  logic [N-1:0]  hgrant;
  logic [1:0]    hmaster;
  logic          hmastlock;
  logic [1:0]    htrans;
  logic [31:0]   haddr;
  logic          hwrite;
  logic [31:0]   hwdata;

  ahb_master_arbiter #(.NUM_MASTERS(N)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans_m  (htrans_m),
    .haddr_m   (haddr_m),
    .hwrite_m  (hwrite_m),
    .hwdata_m  (hwdata_m),
    .hready_in (hready_in),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hwdata    (hwdata)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string       tag;
    logic [3:0]  grant;
    logic [1:0]  master;
    logic        lock;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Drive request, lock and per-master htrans ({m3,m2,m1,m0}) plus ready.
  task automatic apply_stimulus(input logic [3:0] req, input logic [3:0] lck,
                                input logic [7:0] trans, input logic rdy);
    hbusreq   = req;
    hlock     = lck;
    htrans_m  = trans;
    hready_in = rdy;
  endtask

  // Queue the expected state. The muxed values come from the inputs this
  // bench drives for master m (address phase) and master wsrc (data phase).
  task automatic expect_state(input string tag, input logic [3:0] grant,
                              input int m, input logic lock, input int wsrc);
    exp_t e;
    e.tag    = tag;
    e.grant  = grant;
    e.master = 2'(m);
    e.lock   = lock;
    e.trans  = htrans_m[2*m +: 2];
    e.addr   = haddr_m[32*m +: 32];
    e.write  = hwrite_m[m];
    e.wdata  = hwdata_m[32*wsrc +: 32];
    sb.push_back(e);
  endtask

  task automatic compare(input string tag, input string what,
                         input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, what, got, want);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      compare(e.tag, "hgrant",    32'(hgrant),    32'(e.grant));
      compare(e.tag, "hmaster",   32'(hmaster),   32'(e.master));
      compare(e.tag, "hmastlock", 32'(hmastlock), 32'(e.lock));
      compare(e.tag, "htrans",    32'(htrans),    32'(e.trans));
      compare(e.tag, "haddr",     haddr,          e.addr);
      compare(e.tag, "hwrite",    32'(hwrite),    32'(e.write));
      compare(e.tag, "hwdata",    hwdata,         e.wdata);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
    check_output();
  endtask

  // Watchdog: the bench must always end on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rr_grant [8];
    int         rr_master [8];
    int         rr_src [8];

    // Reset with random inputs: master 0 parked and presented on the muxes.
    hresetn   = 1'b0;
    hbusreq   = 4'($urandom);
    hlock     = 4'($urandom);
    htrans_m  = 8'($urandom);
    hwrite_m  = 4'($urandom);
    hready_in = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      haddr_m[32*i +: 32]  = $urandom;
      hwdata_m[32*i +: 32] = $urandom;
    end
    repeat (2) @(posedge hclk);
    #1;
    expect_state("reset", 4'b0001, 0, 1'b0, 0);
    check_output();

    for (int i = 0; i < N; i++) begin
      haddr_m[32*i +: 32]  = 32'hA000_0000 + 32'(i * 32'h110);
      hwdata_m[32*i +: 32] = 32'hD000_0000 + 32'(i * 32'h1001);
    end
    hwrite_m = 4'b1010;
    apply_stimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
    #1 hresetn = 1'b1;

    // Single request from master 2.
    apply_stimulus(4'b0100, 4'b0000, 8'h00, 1'b1);
    expect_state("single_e1", 4'b0100, 0, 1'b0, 0); step();
    expect_state("single_e2", 4'b0100, 2, 1'b0, 0); step();
    expect_state("single_e3", 4'b0100, 2, 1'b0, 2); step();

    // Everyone requests with single NONSEQ transfers. The pointer updates
    // from the pre-edge grant, so each master holds the grant for two edges.
    rr_grant  = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    rr_master = '{2, 3, 3, 0, 0, 1, 1, 2};
    rr_src    = '{2, 2, 3, 3, 0, 0, 1, 1};
    apply_stimulus(4'b1111, 4'b0000, 8'b10_10_10_10, 1'b1);
    for (int s = 0; s < 8; s++) begin
      expect_state($sformatf("rr_%0d", s), rr_grant[s], rr_master[s], 1'b0, rr_src[s]);
      step();
    end

    // Master 1 INCR4 burst; master 3 requests during the SEQ beats.
    apply_stimulus(4'b0010, 4'b0000, 8'b00_00_00_00, 1'b1);
    expect_state("burst_req", 4'b0010, 2, 1'b0, 2); step();
    expect_state("burst_own", 4'b0010, 1, 1'b0, 2); step();
    apply_stimulus(4'b0010, 4'b0000, 8'b00_00_10_00, 1'b1);
    expect_state("burst_nseq", 4'b0010, 1, 1'b0, 1); step();
    apply_stimulus(4'b1010, 4'b0000, 8'b00_00_11_00, 1'b1);
    for (int s = 0; s < 3; s++) begin
      expect_state($sformatf("burst_seq%0d", s), 4'b0010, 1, 1'b0, 1);
      step();
    end
    apply_stimulus(4'b1000, 4'b0000, 8'b00_00_00_00, 1'b1);
    expect_state("burst_end", 4'b1000, 1, 1'b0, 1); step();
    expect_state("burst_m3",  4'b1000, 3, 1'b0, 1); step();

    // Locked master 1 keeps the bus while all masters request.
    apply_stimulus(4'b0010, 4'b0010, 8'b00_00_10_00, 1'b1);
    expect_state("lock_req", 4'b0010, 3, 1'b0, 3); step();
    expect_state("lock_own", 4'b0010, 1, 1'b1, 3); step();
    apply_stimulus(4'b1111, 4'b0010, 8'b00_00_10_00, 1'b1);
    expect_state("lock_hold1", 4'b0010, 1, 1'b1, 1); step();
    expect_state("lock_hold2", 4'b0010, 1, 1'b1, 1); step();
    apply_stimulus(4'b1101, 4'b0000, 8'b00_00_00_00, 1'b1);
    expect_state("lock_release", 4'b0100, 1, 1'b0, 1); step();

    // Three wait states in the middle of a handover freeze everything.
    apply_stimulus(4'b1000, 4'b0000, 8'b00_00_00_00, 1'b0);
    for (int s = 0; s < 3; s++) begin
      expect_state($sformatf("wait_%0d", s), 4'b0100, 1, 1'b0, 1);
      step();
    end
    apply_stimulus(4'b1000, 4'b0000, 8'b00_00_00_00, 1'b1);
    expect_state("wait_done", 4'b1000, 2, 1'b0, 1); step();

    // Master 2 takes the bus and starts a burst; reset lands on its SEQ beat.
    apply_stimulus(4'b0100, 4'b0000, 8'b00_10_00_00, 1'b1);
    expect_state("rst_pre1", 4'b0100, 3, 1'b0, 2); step();
    expect_state("rst_pre2", 4'b0100, 2, 1'b0, 3); step();
    expect_state("rst_pre3", 4'b0100, 2, 1'b0, 2); step();
    apply_stimulus(4'b0010, 4'b0000, 8'b00_11_00_00, 1'b1);
    expect_state("rst_seq", 4'b0100, 2, 1'b0, 2); step();
    #1 hresetn = 1'b0;
    #1;
    expect_state("rst_async", 4'b0001, 0, 1'b0, 0);
    check_output();
    expect_state("rst_held", 4'b0001, 0, 1'b0, 0); step();

    // Normal arbitration resumes after release.
    apply_stimulus(4'b0010, 4'b0000, 8'b00_00_00_00, 1'b1);
    @(negedge hclk);
    hresetn = 1'b1;
    expect_state("resume_e1", 4'b0010, 0, 1'b0, 0); step();
    expect_state("resume_e2", 4'b0010, 1, 1'b0, 0); step();
    expect_state("resume_e3", 4'b0010, 1, 1'b0, 1); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
